operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side operand stage that sits between the register file and the EX stage. It drives the register-file read addresses and receives RD1/RD2. It resolves RAW hazards by bypassing from the MEM and WB stages, stalls upstream when a producer's result is not yet available, and holds the ID/EX pipeline register that feeds the ALU. A saturating counter records stall cycles for performance debug.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 8, opaque EX/MEM/WB control bundle carried through
- CNT_W, 16, stall-counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  source A, source B, destination
- id_uses_rs, id_uses_rt  in  1 each  source is actually read
- id_reg_write, id_mem_read  in  1 each  instruction writes rd / is a load
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  control bundle
- pr1, pr2  out  5 each  register-file read addresses (= id_rs, id_rt, combinational)
- rd1, rd2  in  DATA_W  register-file read data
- mem_reg_write, mem_mem_read  in  1 each  MEM-stage instruction writes / is a load
- mem_rd  in  5  MEM-stage destination
- mem_alu  in  DATA_W  MEM-stage ALU result
- wb_write  in  1  WB write enable (same signal as the register-file write)
- wb_rd  in  5  WB destination
- wb_data  in  DATA_W  WB data
- flush  in  1  kill the ID instruction (taken branch/jump)
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read  out  1 each  registered EX-stage fields
- ex_rd  out  5  registered destination
- ex_op_a, ex_op_b, ex_imm  out  DATA_W  registered operands
- ex_ctrl  out  CTRL_W  registered control
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
- Register 0 always reads as 0 and is never a hazard or bypass target. A source equal to 0 selects constant 0.
- Bypass per source, combinational, in priority order:
  - MEM (mem_reg_write && !mem_mem_read && mem_rd==src): select mem_alu.
  - WB (wb_write && wb_rd==src): select wb_data. This covers the register file's same-cycle write/read.
  - Otherwise: select rd1/rd2.
- A source hits a stage only if its id_uses_* is 1.
- Hazard (stall=1) when id_valid && !flush and either:
  - any used source equals ex_rd with ex_valid && ex_reg_write, because the EX result is not yet computed; or
  - any used source equals mem_rd with mem_mem_read && mem_reg_write, because load data is not yet available.
- On stall: the ID/EX register loads a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0). The ID inputs are expected to be held by upstream.
- On flush: a bubble is loaded and stall is forced to 0. Flush wins over stall.
- Otherwise: the ID/EX register loads {id_valid, id_reg_write, id_mem_read, id_rd, bypassed A, bypassed B, id_imm, id_ctrl}. When id_valid=0, all write/read enables are loaded as 0.
- stall_cnt increments on every cycle where stall=1 and saturates at all-ones.

## Timing
- pr1/pr2 and stall are combinational from the current inputs and ID/EX state. There is no latch of the stall.
- ID/EX outputs update on the posedge of clk: one cycle of latency from ID to EX.
- A dependent on an ALU producer stalls exactly 1 cycle (producer in EX), then bypasses from MEM.
- A dependent on a load stalls exactly 2 cycles (producer in EX, then in MEM), then bypasses from WB.
- Reset (async assert, sync-release expected): every ex_* output is 0, stall_cnt is 0, and no bubble-count wrap occurs. stall is 0 after reset because ex_valid=0, unless a MEM-stage load hazard is present on the inputs.
- Reset asserted mid-stall: the ID/EX register clears immediately and the counter clears.
- When MEM and WB both hit the same source, MEM wins. A WB hit on register 0 is ignored.

## Structure
- Package pf_pkg:
  - REG_W=5
  - REG_ZERO=5'd0
  - Localparams for DATA_W and CTRL_W defaults
  - Typedef-free bundle-width constant EX_BUNDLE_W
- Sub-module fwd_mux (combinational, one per source): inputs src, uses, the MEM/WB bypass fields and rf data; outputs data. operand_fetch instantiates it twice (A, B). Hazard logic and the ID/EX register stay in operand_fetch.

## Test plan
- Independent ops: rs=3, rt=4, rd1=3, rd2=4, no hazards -> next cycle ex_op_a=3, ex_op_b=4, ex_valid=1, stall never 1.
- ALU RAW: ADD rd=5, then SUB rs=5 -> 1 stall cycle with an EX bubble, then ex_op_a = mem_alu (e.g. 0x1234), stall_cnt=1.
- Load-use: LW rd=7, then ADD rt=7 -> 2 stall cycles, then ex_op_b = wb_data (0xDEADBEEF), stall_cnt=2.
- Same-cycle WB: wb_write=1, wb_rd=9, wb_data=0x55, rs=9, rd1=old 9 -> ex_op_a=0x55. With rs=0 and wb_rd=0 -> ex_op_a=0.
- Flush during a hazard: the stall condition holds and flush=1 -> stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
- Reset mid-stall: assert rst_n=0 while stall_cnt=3 and ex_valid=1 -> all ex_* outputs and stall_cnt read 0 before the next clock edge.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared widths and constants for the operand-fetch stage.
package pf_pkg;
    localparam int              REG_W      = 5;
    localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;
    localparam int              DATA_W_DEF = 32;
    localparam int              CTRL_W_DEF = 8;
    // valid + reg_write + mem_read + rd + op_a + op_b + imm + ctrl
    localparam int              EX_BUNDLE_W = 3 + REG_W + 3*DATA_W_DEF + CTRL_W_DEF;
endpackage

// File: rtl/fwd_mux.sv
// Per-source operand bypass: MEM beats WB beats the register file; r0 is always zero.
module fwd_mux
    import pf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [REG_W-1:0]  src,
    input  logic              uses,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic              wb_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data
);
    logic live, mem_hit, wb_hit;

    // A load in MEM has no data yet; the hazard logic stalls on it instead.
    assign live    = uses && (src != REG_ZERO);
    assign mem_hit = live && mem_reg_write && !mem_mem_read && (mem_rd == src);
    assign wb_hit  = live && wb_write && (wb_rd == src);

    always_comb begin
        data = rf_data;
        if (src == REG_ZERO) data = '0;
        else if (mem_hit)    data = mem_alu;
        else if (wb_hit)     data = wb_data;
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand stage: register-file addressing, MEM/WB bypass, RAW stall detection,
// the ID/EX pipeline register and a saturating stall-cycle counter.
module operand_fetch
    import pf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [REG_W-1:0]  pr1,
    output logic [REG_W-1:0]  pr2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic              wb_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int NSRC = 2;

    logic [NSRC-1:0][REG_W-1:0]  src;
    logic [NSRC-1:0]             uses;
    logic [NSRC-1:0][DATA_W-1:0] rf;
    logic [NSRC-1:0][DATA_W-1:0] byp;
    logic [NSRC-1:0]             dep;

    assign pr1  = id_rs;
    assign pr2  = id_rt;
    assign src  = {id_rt, id_rs};
    assign uses = {id_uses_rt, id_uses_rs};
    assign rf   = {rd2, rd1};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_mux #(.DATA_W(DATA_W)) u_fwd (
            .src           (src[i]),
            .uses          (uses[i]),
            .mem_reg_write (mem_reg_write),
            .mem_mem_read  (mem_mem_read),
            .mem_rd        (mem_rd),
            .mem_alu       (mem_alu),
            .wb_write      (wb_write),
            .wb_rd         (wb_rd),
            .wb_data       (wb_data),
            .rf_data       (rf[i]),
            .data          (byp[i])
        );
    end

    // Producer still in EX, or a load in MEM whose data arrives only at WB.
    always_comb begin
        dep = '0;
        for (int i = 0; i < NSRC; i++) begin
            dep[i] = uses[i] && (src[i] != REG_ZERO) &&
                     ((ex_valid && ex_reg_write && (ex_rd == src[i])) ||
                      (mem_mem_read && mem_reg_write && (mem_rd == src[i])));
        end
    end

    assign stall = id_valid && !flush && (|dep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rd        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            stall_cnt    <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush || stall) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_rd        <= '0;
                ex_op_a      <= '0;
                ex_op_b      <= '0;
                ex_imm       <= '0;
                ex_ctrl      <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_reg_write <= id_valid && id_reg_write;
                ex_mem_read  <= id_valid && id_mem_read;
                ex_rd        <= id_rd;
                ex_op_a      <= byp[0];
                ex_op_b      <= byp[1];
                ex_imm       <= id_imm;
                ex_ctrl      <= id_ctrl;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a rule-level reference model checked every cycle.
module tb_operand_fetch;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 16;

    logic          clk, rst_n;
    logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic [4:0]    pr1, pr2;
    logic [DW-1:0] rd1, rd2;
    logic          mem_reg_write, mem_mem_read;
    logic [4:0]    mem_rd;
    logic [DW-1:0] mem_alu;
    logic          wb_write;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush, stall;
    logic          ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]    ex_rd;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    operand_fetch #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .pr1(pr1), .pr2(pr2), .rd1(rd1), .rd2(rd2),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd), .mem_alu(mem_alu),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the EX register should hold, derived from the rules.
    logic          m_valid, m_rw, m_mr;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [CW-1:0] m_ctrl;
    int            m_cnt;

    function automatic logic [DW-1:0] want_src(logic [4:0] s, logic u, logic [DW-1:0] rf);
        if (s == 5'd0) return '0;
        if (u && mem_reg_write && !mem_mem_read && mem_rd == s) return mem_alu;
        if (u && wb_write && wb_rd == s) return wb_data;
        return rf;
    endfunction

    function automatic logic needs_wait(logic [4:0] s, logic u);
        if (!u || s == 5'd0) return 1'b0;
        return (m_valid && m_rw && m_rd == s) || (mem_mem_read && mem_reg_write && mem_rd == s);
    endfunction

    function automatic logic want_stall();
        return id_valid && !flush && (needs_wait(id_rs, id_uses_rs) || needs_wait(id_rt, id_uses_rt));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_rd <= '0;
            m_a <= '0; m_b <= '0; m_imm <= '0; m_ctrl <= '0; m_cnt <= 0;
        end else begin
            if (want_stall() && m_cnt < (1 << NW) - 1) m_cnt <= m_cnt + 1;
            if (flush || want_stall()) begin
                m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0;
            end else begin
                m_valid <= id_valid;
                m_rw    <= id_valid && id_reg_write;
                m_mr    <= id_valid && id_mem_read;
                m_rd    <= id_rd;
                m_a     <= want_src(id_rs, id_uses_rs, rd1);
                m_b     <= want_src(id_rt, id_uses_rt, rd2);
                m_imm   <= id_imm;
                m_ctrl  <= id_ctrl;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", stall, want_stall());
            chk("pr1", pr1, id_rs);
            chk("pr2", pr2, id_rt);
            chk("ex_valid", ex_valid, m_valid);
            chk("ex_reg_write", ex_reg_write, m_rw);
            chk("ex_mem_read", ex_mem_read, m_mr);
            chk("stall_cnt", stall_cnt, m_cnt[NW-1:0]);
            if (m_valid) begin
                chk("ex_rd", ex_rd, m_rd);
                chk("ex_op_a", ex_op_a, m_a);
                chk("ex_op_b", ex_op_b, m_b);
                chk("ex_imm", ex_imm, m_imm);
                chk("ex_ctrl", ex_ctrl, m_ctrl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_reg_write = rw; id_mem_read = mr;
        id_imm = {27'd0, rd} + 32'h100; id_ctrl = {3'd0, rd} ^ 8'hA5;
    endtask

    task automatic clr_bp();
        mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0; mem_alu = 0;
        wb_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        clr_bp();
        flush = 0; rd1 = 0; rd2 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        clr_bp();
        flush = 0; rd1 = 0; rd2 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst ex_valid", ex_valid, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst stall", stall, 0);

        // Independent operands
        set_id(1, 3, 4, 10, 1, 1, 1, 0); rd1 = 3; rd2 = 4;
        #1 chk("indep stall", stall, 0);
        tick();
        chk("indep op_a", ex_op_a, 3);
        chk("indep op_b", ex_op_b, 4);
        chk("indep valid", ex_valid, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ALU RAW: one stall, then bypass from MEM
        do_reset();
        set_id(1, 1, 2, 5, 1, 1, 1, 0);
        tick();
        set_id(1, 5, 6, 8, 1, 1, 1, 0); rd1 = 32'hBAD;
        #1 chk("alu stall", stall, 1);
        tick();
        chk("alu bubble", ex_valid, 0);
        chk("alu cnt1", stall_cnt, 1);
        mem_reg_write = 1; mem_rd = 5; mem_alu = 32'h1234;
        #1 chk("alu release", stall, 0);
        tick();
        chk("alu op_a", ex_op_a, 32'h1234);
        chk("alu cnt", stall_cnt, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0); clr_bp();
        tick();

        // Load-use: two stalls, then bypass from WB
        do_reset();
        set_id(1, 1, 2, 7, 1, 1, 1, 1);
        tick();
        set_id(1, 3, 7, 9, 1, 1, 1, 0); rd2 = 32'hBAD;
        #1 chk("ld stall1", stall, 1);
        tick();
        chk("ld cnt1", stall_cnt, 1);
        mem_reg_write = 1; mem_mem_read = 1; mem_rd = 7;
        #1 chk("ld stall2", stall, 1);
        tick();
        chk("ld cnt2", stall_cnt, 2);
        clr_bp(); wb_write = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        #1 chk("ld release", stall, 0);
        tick();
        chk("ld op_b", ex_op_b, 32'hDEADBEEF);
        chk("ld cnt", stall_cnt, 2);
        chk("ld valid", ex_valid, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0); clr_bp();
        tick();

        // Same-cycle WB, r0 handling, MEM-over-WB priority, unused sources
        do_reset();
        set_id(1, 9, 0, 11, 1, 1, 1, 0); rd1 = 32'h11; rd2 = 32'h22;
        wb_write = 1; wb_rd = 9; wb_data = 32'h55;
        tick();
        chk("wb op_a", ex_op_a, 32'h55);
        chk("r0 op_b", ex_op_b, 0);
        set_id(1, 0, 13, 12, 1, 1, 1, 0); rd1 = 32'h99; wb_rd = 0; wb_data = 32'h77;
        tick();
        chk("wb r0 op_a", ex_op_a, 0);
        set_id(1, 9, 9, 14, 1, 1, 1, 0); rd1 = 32'h11; rd2 = 32'h22;
        mem_reg_write = 1; mem_rd = 9; mem_alu = 32'hAA; wb_rd = 9; wb_data = 32'h55;
        tick();
        chk("prio op_a", ex_op_a, 32'hAA);
        chk("prio op_b", ex_op_b, 32'hAA);
        set_id(1, 9, 9, 15, 0, 0, 1, 0);
        tick();
        chk("unused op_a", ex_op_a, 32'h11);
        chk("unused op_b", ex_op_b, 32'h22);
        set_id(0, 1, 2, 3, 1, 1, 1, 1);
        tick();
        chk("inval rw", ex_reg_write, 0);
        chk("inval mr", ex_mem_read, 0);
        clr_bp();

        // Flush while the hazard condition holds
        do_reset();
        set_id(1, 1, 2, 5, 1, 1, 1, 0);
        tick();
        set_id(1, 5, 2, 6, 1, 1, 1, 0); flush = 1;
        #1 chk("flush stall", stall, 0);
        tick();
        chk("flush bubble", ex_valid, 0);
        chk("flush cnt", stall_cnt, 0);
        flush = 0;
        tick();

        // Reset asserted mid-stall
        do_reset();
        set_id(1, 1, 2, 7, 1, 1, 1, 0);
        tick();
        set_id(1, 3, 4, 12, 1, 1, 1, 0); rd1 = 32'h33; rd2 = 32'h44;
        mem_reg_write = 1; mem_mem_read = 1; mem_rd = 3;
        repeat (3) tick();
        clr_bp();
        tick();
        chk("pre cnt", stall_cnt, 3);
        chk("pre valid", ex_valid, 1);
        set_id(1, 12, 4, 13, 1, 1, 1, 0);
        #1 chk("pre stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst valid", ex_valid, 0);
        chk("arst rw", ex_reg_write, 0);
        chk("arst mr", ex_mem_read, 0);
        chk("arst rd", ex_rd, 0);
        chk("arst op_a", ex_op_a, 0);
        chk("arst op_b", ex_op_b, 0);
        chk("arst imm", ex_imm, 0);
        chk("arst ctrl", ex_ctrl, 0);
        chk("arst cnt", stall_cnt, 0);
        chk("arst stall", stall, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
